// File: rtl/kyber_pkg.sv
// Shared types and helpers for the sequential Kyber-style decrypt core.
package kyber_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        REDUCE,
        DONE
    } kyber_dec_state_e;

    // Wide signed coefficient used for products and residue arithmetic.
    typedef logic signed [63:0] kyber_coef_t;

    function automatic int mod_q(input kyber_coef_t x, input int q);
        kyber_coef_t r;
        r = x % kyber_coef_t'(q);
        if (r < 0) begin
            r = r + kyber_coef_t'(q);
        end
        return int'(r);
    endfunction

    function automatic logic decode_bit(input int r, input int lo, input int hi);
        return (r >= lo) && (r <= hi);
    endfunction

endpackage

// File: rtl/kyber_decrypt_seq_mac.sv
// Negacyclic multiply-accumulate: one u[k][j]*s[k][(i-j) mod N] term per cycle.
module kyber_negacyclic_mac
    import kyber_pkg::*;
#(
    parameter int N  = 4,
    parameter int K  = 2,
    parameter int W  = 5,
    parameter int AW = 14,
    parameter int IW = 2,
    parameter int KW = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr,
    input  logic                          en,
    input  logic [IW-1:0]                 i_idx,
    input  logic [IW-1:0]                 j_idx,
    input  logic [KW-1:0]                 k_idx,
    input  logic [K-1:0][N-1:0][W-1:0]    s_op,
    input  logic [K-1:0][N-1:0][W-1:0]    u_op,
    output logic signed [AW-1:0]          acc
);

    logic [IW-1:0]        t;
    logic                 sub;
    logic [2*W-1:0]       prod;
    logic signed [AW-1:0] term;
    logic signed [AW-1:0] acc_d;
    logic signed [AW-1:0] acc_q;

    always_comb begin
        sub  = j_idx > i_idx;
        // Terms with j>i wrap past x^N and pick up a minus sign.
        t    = IW'(int'(i_idx) - int'(j_idx) + (sub ? N : 0));
        prod = u_op[k_idx][j_idx] * s_op[k_idx][t];
        term = $signed({{(AW-2*W){1'b0}}, prod});
        if (sub) begin
            term = -term;
        end
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + term;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/kyber_decrypt_seq.sv
// Sequential Kyber-style decrypt: m = Decode(v - s^T u) over Z_Q[x]/(x^N+1).
// Optional KYBER_DEC_COEF_OUT_EN exposes the reduced residues on coef_out.
module kyber_decrypt_seq
    import kyber_pkg::*;
#(
    parameter int N      = 4,
    parameter int K      = 2,
    parameter int Q      = 17,
    parameter int W      = $clog2(Q),
    parameter int DEC_LO = (Q + 3) / 4,
    parameter int DEC_HI = Q - DEC_LO + 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [K-1:0][N-1:0][W-1:0] secret_key,
    input  logic [K-1:0][N-1:0][W-1:0] cipher_u,
    input  logic [N-1:0][W-1:0]        cipher_v,
    output logic                       busy,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N-1:0]               m_bits
`ifdef KYBER_DEC_COEF_OUT_EN
    ,
    output logic [N-1:0][W-1:0]        coef_out
`endif
);

    localparam int IW = $clog2(N);
    localparam int KW = (K > 1) ? $clog2(K) : 1;
    localparam int AW = 2 * W + $clog2(K * N) + 1;

    kyber_dec_state_e state_d, state_q;

    logic [IW-1:0] i_d, i_q;
    logic [IW-1:0] j_d, j_q;
    logic [KW-1:0] k_d, k_q;

    logic [K-1:0][N-1:0][W-1:0] s_d, s_q;
    logic [K-1:0][N-1:0][W-1:0] u_d, u_q;
    logic [N-1:0][W-1:0]        v_d, v_q;
    logic [N-1:0]               m_d, m_q;
`ifdef KYBER_DEC_COEF_OUT_EN
    logic [N-1:0][W-1:0]        coef_d, coef_q;
`endif

    logic                 mac_en;
    logic                 mac_clr;
    logic signed [AW-1:0] acc;
    logic signed [AW:0]   diff;
    logic [W-1:0]         r;
    logic                 mbit;

    kyber_negacyclic_mac #(
        .N  (N),
        .K  (K),
        .W  (W),
        .AW (AW),
        .IW (IW),
        .KW (KW)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (mac_clr),
        .en    (mac_en),
        .i_idx (i_q),
        .j_idx (j_q),
        .k_idx (k_q),
        .s_op  (s_q),
        .u_op  (u_q),
        .acc   (acc)
    );

    always_comb begin
        diff = $signed({{(AW + 1 - W){1'b0}}, v_q[i_q]}) - acc;
        r    = W'(mod_q(kyber_coef_t'(diff), Q));
        mbit = decode_bit(int'(r), DEC_LO, DEC_HI);
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        s_d     = s_q;
        u_d     = u_q;
        v_d     = v_q;
        m_d     = m_q;
`ifdef KYBER_DEC_COEF_OUT_EN
        coef_d  = coef_q;
`endif
        mac_en  = 1'b0;
        mac_clr = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = MAC;
                    s_d     = secret_key;
                    u_d     = cipher_u;
                    v_d     = cipher_v;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    mac_clr = 1'b1;
                end
            end
            MAC: begin
                mac_en = 1'b1;
                if (j_q == IW'(N - 1)) begin
                    j_d = '0;
                    if (k_q == KW'(K - 1)) begin
                        k_d     = '0;
                        state_d = REDUCE;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            REDUCE: begin
                mac_clr   = 1'b1;
                m_d[i_q]  = mbit;
`ifdef KYBER_DEC_COEF_OUT_EN
                coef_d[i_q] = r;
`endif
                if (i_q == IW'(N - 1)) begin
                    i_d     = '0;
                    state_d = DONE;
                end else begin
                    i_d     = i_q + 1'b1;
                    state_d = MAC;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            s_q     <= '0;
            u_q     <= '0;
            v_q     <= '0;
            m_q     <= '0;
`ifdef KYBER_DEC_COEF_OUT_EN
            coef_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            s_q     <= s_d;
            u_q     <= u_d;
            v_q     <= v_d;
            m_q     <= m_d;
`ifdef KYBER_DEC_COEF_OUT_EN
            coef_q  <= coef_d;
`endif
        end
    end

    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign m_bits    = m_q;
`ifdef KYBER_DEC_COEF_OUT_EN
    assign coef_out  = coef_q;
`endif

endmodule

// File: tb/tb_kyber_decrypt_seq.sv
// Self-checking bench for kyber_decrypt_seq (N=4, K=2, Q=17).
module tb_kyber_decrypt_seq;

    localparam int N   = 4;
    localparam int K   = 2;
    localparam int Q   = 17;
    localparam int W   = 5;
    localparam int LO  = 5;
    localparam int HI  = 13;
    localparam int LAT = 37;

    typedef logic [K-1:0][N-1:0][W-1:0] kv_t;
    typedef logic [N-1:0][W-1:0]        pv_t;

    typedef struct {
        string        name;
        kv_t          s;
        kv_t          u;
        pv_t          v;
        logic [N-1:0] m;
        pv_t          c;
    } vec_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    kv_t          secret_key;
    kv_t          cipher_u;
    pv_t          cipher_v;
    logic         busy;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] m_bits;
`ifdef KYBER_DEC_COEF_OUT_EN
    pv_t          coef_out;
`endif

    int tests = 0;
    int fails = 0;

    kyber_decrypt_seq #(.N(N), .K(K), .Q(Q)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .secret_key (secret_key),
        .cipher_u   (cipher_u),
        .cipher_v   (cipher_v),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .m_bits     (m_bits)
`ifdef KYBER_DEC_COEF_OUT_EN
        ,
        .coef_out   (coef_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic kv_t rand_kv();
        kv_t r;
        for (int k = 0; k < K; k++)
            for (int j = 0; j < N; j++)
                r[k][j] = W'($urandom_range(Q - 1, 0));
        return r;
    endfunction

    function automatic pv_t rand_pv();
        pv_t r;
        for (int j = 0; j < N; j++) r[j] = W'($urandom_range(Q - 1, 0));
        return r;
    endfunction

    function automatic pv_t mk_pv(input int a, input int b, input int c, input int d);
        pv_t r;
        r[0] = W'(a);
        r[1] = W'(b);
        r[2] = W'(c);
        r[3] = W'(d);
        return r;
    endfunction

    // Ring product by degree: x^a * x^b = x^(a+b), with x^N = -1.
    task automatic model(input kv_t s, input kv_t u, input pv_t v,
                         output logic [N-1:0] m, output pv_t c);
        int p[N];
        int r;
        for (int n = 0; n < N; n++) p[n] = 0;
        for (int k = 0; k < K; k++)
            for (int a = 0; a < N; a++)
                for (int b = 0; b < N; b++) begin
                    if (a + b < N) p[a + b] += int'(u[k][a]) * int'(s[k][b]);
                    else p[a + b - N] -= int'(u[k][a]) * int'(s[k][b]);
                end
        for (int n = 0; n < N; n++) begin
            r = (int'(v[n]) - p[n]) % Q;
            if (r < 0) r += Q;
            c[n] = W'(r);
            m[n] = (r >= LO) && (r <= HI);
        end
    endtask

    task automatic run_op(input kv_t s, input kv_t u, input pv_t v,
                          input logic rdy, output int lat);
        secret_key = s;
        cipher_u   = u;
        cipher_v   = v;
        out_ready  = rdy;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        secret_key = rand_kv();
        cipher_u   = rand_kv();
        cipher_v   = rand_pv();
        chk("busy_after_start", busy, 1);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (out_valid !== 1'b1) chk("timeout_out_valid", out_valid, 1);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("busy_after_hs", busy, 0);
        chk("valid_after_hs", out_valid, 0);
    endtask

    vec_t         tbl[3];
    logic [N-1:0] m_exp;
    pv_t          c_exp;
    int           lat;
    int           n;
    kv_t          s_r;
    kv_t          u_r;
    pv_t          v_r;
    logic         rdy;

    initial begin
        tbl[0].name = "pass_through";
        tbl[0].s = '0;
        tbl[0].u = '0;
        tbl[0].v = mk_pv(9, 0, 4, 13);
        tbl[0].m = 4'b1001;
        tbl[0].c = mk_pv(9, 0, 4, 13);
        tbl[1].name = "negacyclic_wrap";
        tbl[1].s = '0;
        tbl[1].u = '0;
        tbl[1].s[0] = mk_pv(0, 1, 0, 0);
        tbl[1].u[0] = mk_pv(0, 0, 0, 1);
        tbl[1].v = mk_pv(8, 0, 0, 0);
        tbl[1].m = 4'b0001;
        tbl[1].c = mk_pv(9, 0, 0, 0);
        tbl[2].name = "thresholds";
        tbl[2].s = '0;
        tbl[2].u = rand_kv();
        tbl[2].v = mk_pv(4, 5, 13, 14);
        tbl[2].m = 4'b0110;
        tbl[2].c = mk_pv(4, 5, 13, 14);

        rst_n      = 1'b0;
        start      = 1'b0;
        out_ready  = 1'b0;
        secret_key = '0;
        cipher_u   = '0;
        cipher_v   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_m", m_bits, 0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("idle_busy", busy, 0);
        chk("idle_valid", out_valid, 0);

        for (int i = 0; i < 3; i++) begin
            run_op(tbl[i].s, tbl[i].u, tbl[i].v, 1'b0, lat);
            chk({tbl[i].name, "_lat"}, lat, LAT);
            chk({tbl[i].name, "_m"}, m_bits, tbl[i].m);
`ifdef KYBER_DEC_COEF_OUT_EN
            chk({tbl[i].name, "_coef"}, coef_out, tbl[i].c);
`endif
            handshake();
        end

        // Restart attempt while busy, then backpressure and start-at-handshake.
        secret_key = '0;
        cipher_u   = '0;
        cipher_v   = mk_pv(9, 0, 4, 13);
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 1;
        while (n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        start      = 1'b1;
        secret_key = rand_kv();
        cipher_u   = rand_kv();
        cipher_v   = mk_pv(0, 16, 0, 16);
        @(posedge clk);
        #1;
        n++;
        start = 1'b0;
        while (out_valid !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("restart_lat", n, LAT);
        chk("restart_m", m_bits, 4'b1001);
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            chk("bp_valid", out_valid, 1);
            chk("bp_m", m_bits, 4'b1001);
        end
        chk("bp_busy", busy, 1);
        start     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        out_ready = 1'b0;
        chk("hs_busy", busy, 0);
        chk("hs_valid", out_valid, 0);
        @(posedge clk);
        #1;
        chk("hs_start_ignored", busy, 0);

        // Asynchronous reset in the middle of a computation.
        secret_key = rand_kv();
        cipher_u   = rand_kv();
        cipher_v   = rand_pv();
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 1;
        while (n < 15) begin
            @(posedge clk);
            #1;
            n++;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_m", m_bits, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        s_r = rand_kv();
        u_r = rand_kv();
        v_r = rand_pv();
        model(s_r, u_r, v_r, m_exp, c_exp);
        run_op(s_r, u_r, v_r, 1'b0, lat);
        chk("postrst_lat", lat, LAT);
        chk("postrst_m", m_bits, m_exp);
        handshake();

        for (int i = 0; i < 200; i++) begin
            s_r = rand_kv();
            u_r = rand_kv();
            v_r = rand_pv();
            rdy = 1'($urandom_range(1, 0));
            model(s_r, u_r, v_r, m_exp, c_exp);
            run_op(s_r, u_r, v_r, rdy, lat);
            chk("rand_lat", lat, LAT);
            chk("rand_m", m_bits, m_exp);
`ifdef KYBER_DEC_COEF_OUT_EN
            chk("rand_coef", coef_out, c_exp);
`endif
            if (!rdy) begin
                repeat ($urandom_range(3, 0)) begin
                    @(posedge clk);
                    #1;
                    chk("rand_hold_valid", out_valid, 1);
                end
            end
            handshake();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/kyber_decrypt_seq.md
# kyber_decrypt_seq

- Sequential, parametrised Kyber-style decryption core that recovers an N-bit message from a module-rank-K ciphertext (u, v) and secret key s.
- Computes m_i = Decode((v − sᵀ·u) mod Q) over the negacyclic ring Z_Q[x]/(x^N+1).
- Uses one time-shared multiply-accumulate datapath, with a start/busy launch and a valid/ready result handshake.
- Successor to the fixed N=4, K=2, Q=17 combinational decrypt; it sits between the ciphertext buffer and the message consumer.

## Interface
Parameters:
- N, 4 — polynomial degree (coefficients per polynomial), ≥2.
- K, 2 — module rank (polynomials per key/u vector), ≥1.
- Q, 17 — modulus, ≥3.
- W, $clog2(Q) — coefficient width.
- DEC_LO, (Q+3)/4 — lowest residue decoded as 1.
- DEC_HI, Q−DEC_LO+1 — highest residue decoded as 1. For Q=17: 5..13.

Ports:
- clk, in, 1 — clock.
- rst_n, in, 1 — asynchronous active-low reset.
- start, in, 1 — launch request; honoured only in IDLE.
- secret_key, in, [K][N]×W — s, unsigned residues in [0,Q).
- cipher_u, in, [K][N]×W — u, unsigned residues in [0,Q).
- cipher_v, in, [N]×W — v, unsigned residues in [0,Q).
- busy, out, 1 — high from the cycle after an accepted start until the result handshake completes.
- out_valid, out, 1 — m_bits holds a completed result.
- out_ready, in, 1 — consumer accepts the result.
- m_bits, out, N — decoded message; bit i comes from coefficient i.

## Operation
- FSM states: IDLE, MAC, REDUCE, DONE.
  - IDLE→MAC on start. All of s, u and v are captured into internal registers at that edge.
  - Inputs may change freely afterwards.
- MAC: for output coefficient i, step k over 0..K−1 (outer) and j over 0..N−1 (inner), one product per cycle.
  - Index t=(i−j) mod N.
  - Term = u[k][j]·s[k][t]. It is added when j≤i and subtracted when j>i (negacyclic wrap).
  - The accumulator is signed, width 2W+$clog2(K·N)+1. No modular reduction happens inside the MAC.
  - The accumulator clears at the start of each coefficient.
- MAC→REDUCE after K·N cycles for that coefficient.
- REDUCE, one cycle:
  - r = (v[i] − acc) mod Q, normalised into [0,Q) including for negative values.
  - m_bits[i] = (DEC_LO ≤ r ≤ DEC_HI).
  - Then i≠N−1 → MAC with i+1; i=N−1 → DONE.
- DONE:
  - out_valid=1 and m_bits is held stable.
  - On out_valid&&out_ready → IDLE, clearing out_valid and busy.
- Boundary rules:
  - start while busy: ignored, no restart.
  - start in the same cycle as the DONE handshake: ignored (the FSM passes through IDLE first).
  - out_ready outside DONE: ignored.
  - Backpressure in DONE: hold indefinitely.
  - Reset mid-operation: immediate return to IDLE, with all counters, the accumulator and captured operands cleared.
- Out-of-range inputs (≥Q) are undefined. Verification only drives residues in [0,Q).

## Timing
- Reset values: busy=0, out_valid=0, m_bits=0, state=IDLE, all counters 0.
- start sampled high at edge T:
  - busy=1 from T+1.
  - out_valid=1 from T + N·(K·N+1) + 1. For defaults this is T+37.
- m_bits bits update during REDUCE cycles. The value is architecturally valid only while out_valid=1.
- Minimum start-to-start spacing is N·(K·N+1)+2 cycles with out_ready tied high.

## Configuration
- `KYBER_DEC_COEF_OUT_EN` defined:
  - Adds output port coef_out, [N]×W, reset 0.
  - It holds each normalised residue r, written in REDUCE and valid with out_valid.
- Macro undefined: port and registers absent; behaviour otherwise identical.

## Structure
- Package kyber_pkg holds:
  - the state enum kyber_dec_state_e;
  - a function mod_q(signed value, Q) returning [0,Q);
  - a function decode_bit(r, lo, hi);
  - the shared coefficient typedef used across the multiply blocks.
- One sub-module: kyber_negacyclic_mac. Given i, j and k it computes t, the sign and the signed product, and accumulates. The top level owns the FSM, operand capture, REDUCE and the handshake.

## Test plan
All cases use N=4, K=2, Q=17.
- **Pass-through:** s=0, u=0, v=[9,0,4,13] → m_bits=4'b1001. out_valid exactly 37 cycles after start.
- **Negacyclic wrap:** s[0]=[0,1,0,0], u[0]=[0,0,0,1], all else 0, v=[8,0,0,0] → coef0=9, m_bits=4'b0001. With the macro defined, coef_out=[9,0,0,0].
- **Thresholds:** s=0, v=[4,5,13,14] → m_bits=4'b0110.
- **Protocol:** start pulsed again at T+10 is ignored, and the result is unchanged. Holding out_ready=0 for 20 cycles in DONE keeps out_valid and m_bits stable; busy drops on the cycle after the handshake.
- **Reset mid-operation:** rst_n low at T+15 → busy, out_valid and m_bits are 0 next cycle. A new start gives a correct result 37 cycles later.
- **Random:** 200 random vectors with residues in [0,17), checked against a reference-model ring multiply and decode.
